// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART frame arbiter: frame constants, channel count
// and the sequencer state encoding.
package uart_tx_arbiter_pkg;

    localparam int unsigned NUM_CH      = 4;
    localparam logic [7:0]  SYNC_DEF    = 8'hA5;
    localparam logic [7:0]  ID_BASE_DEF = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_WAIT = 2'b10
    } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter4.sv
// Combinational round-robin search over four requesters, starting at the
// channel after the pointer and wrapping; the pointer itself is the lowest priority.
module rr_arbiter4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [1:0] gnt_o,
    output logic       any_o
);

    logic [1:0] cand_s;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        gnt_o  = 2'd0;
        any_o  = 1'b0;
        cand_s = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            cand_s = ptr_i + i[1:0];
            if (req_i[cand_s]) begin
                gnt_o = cand_s;
                any_o = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Four-channel round-robin arbiter that sends SYNC/ID/DATA/checksum frames
// through a single-byte UART transmitter handshake.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter logic [7:0] SYNC    = SYNC_DEF,
    parameter logic [7:0] ID_BASE = ID_BASE_DEF
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [3:0]  i_Req,
    input  logic [31:0] i_Data,
    output logic [3:0]  o_Ack,
    output logic        o_fBusy,
    output logic        o_fFrameDone,
    output logic        o_fTx,
    output logic [7:0]  o_TxData,
    input  logic        i_fReady,
    input  logic        i_fDone
);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] ch_q, ch_d;
    logic [7:0] data_q, data_d;
    logic [3:0] ack_q, ack_d;
    logic [1:0] gnt_s;
    logic       any_s;
    logic [7:0] id_s;
    logic [7:0] tx_byte_s;

    rr_arbiter4 u_rr_arbiter4 (
        .req_i (i_Req),
        .ptr_i (ptr_q),
        .gnt_o (gnt_s),
        .any_o (any_s)
    );

    assign id_s     = ID_BASE + {6'd0, ch_q};
    assign o_Ack    = ack_q;
    assign o_fBusy  = (state_q != ST_IDLE);

    // Frame byte selected by the byte index.
    always_comb begin
        case (idx_q)
            2'd0:    tx_byte_s = SYNC;
            2'd1:    tx_byte_s = id_s;
            2'd2:    tx_byte_s = data_q;
            2'd3:    tx_byte_s = SYNC ^ id_s ^ data_q;
            default: tx_byte_s = SYNC;
        endcase
    end

    // Sequencer state and grant registers; pointer resets to 3 so channel 0 leads.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            ptr_q   <= 2'd3;
            ch_q    <= 2'd0;
            data_q  <= 8'd0;
            ack_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state logic and the combinational handshake outputs.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ptr_d        = ptr_q;
        ch_d         = ch_q;
        data_d       = data_q;
        ack_d        = 4'd0;
        o_fTx        = 1'b0;
        o_fFrameDone = 1'b0;
        o_TxData     = 8'd0;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    state_d = ST_SEND;
                    ch_d    = gnt_s;
                    ptr_d   = gnt_s;
                    idx_d   = 2'd0;
                    data_d  = i_Data[{gnt_s, 3'b000} +: 8];
                    ack_d   = 4'b0001 << gnt_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                o_fTx    = i_fReady;
                o_TxData = tx_byte_s;
                if (i_fReady) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_WAIT: begin
                o_TxData = tx_byte_s;
                if (i_fDone) begin
                    if (idx_q == 2'd3) begin
                        state_d      = ST_IDLE;
                        o_fFrameDone = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                        idx_d   = idx_q + 2'd1;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a transmitter model, a frame-level
// reference model compared every cycle, and directed frame/order expectations.
module tb_uart_tx_arbiter;

    localparam int BYTE_T = 10;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b0;
    logic [3:0]  i_Req = 4'd0;
    logic [31:0] i_Data = 32'd0;
    logic        i_fReady = 1'b0;
    logic        i_fDone = 1'b0;
    logic [3:0]  o_Ack;
    logic        o_fBusy;
    logic        o_fFrameDone;
    logic        o_fTx;
    logic [7:0]  o_TxData;

    int checks = 0;
    int failures = 0;

    uart_tx_arbiter dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_Req        (i_Req),
        .i_Data       (i_Data),
        .o_Ack        (o_Ack),
        .o_fBusy      (o_fBusy),
        .o_fFrameDone (o_fFrameDone),
        .o_fTx        (o_fTx),
        .o_TxData     (o_TxData),
        .i_fReady     (i_fReady),
        .i_fDone      (i_fDone)
    );

    always #10 i_Clk = ~i_Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    int         phase = 0;      // 0 no frame, 1 awaiting strobe, 2 awaiting done
    int         bidx = 0;
    logic [7:0] exp_b [4];
    int         m_ptr = 3;
    logic [3:0] prev_req = 4'd0;
    logic [31:0] prev_data = 32'd0;
    int         frames = 0;
    int         served[$];
    int         gaps[$];
    int         ack_cnt[4];
    int         gap_run = 0;
    logic [3:0] m_ack;
    int         m_c;
    logic [7:0] m_id, m_d;

    // Frame-level model: round-robin from the last served channel, 4-byte frame.
    initial forever begin
        @(negedge i_Clk);
        if (!i_Rst) begin
            chk("reset_outputs", {17'd0, o_Ack, o_fBusy, o_fFrameDone, o_fTx, o_TxData}, 32'd0);
            phase = 0; m_ptr = 3; prev_req = 4'd0; gap_run = 0;
        end else begin
            m_ack = 4'd0;
            m_c = 0;
            for (int k = 1; k <= 4; k++) begin
                if (m_ack == 4'd0 && prev_req[(m_ptr + k) % 4]) begin
                    m_c = (m_ptr + k) % 4;
                    m_ack[m_c] = 1'b1;
                end
            end
            chk("ack", {28'd0, o_Ack}, {28'd0, m_ack});
            if (m_ack != 4'd0) begin
                m_ptr = m_c;
                m_id = 8'h30 + 8'(m_c);
                m_d = prev_data[8*m_c +: 8];
                exp_b[0] = 8'hA5;
                exp_b[1] = m_id;
                exp_b[2] = m_d;
                exp_b[3] = 8'hA5 ^ m_id ^ m_d;
                bidx = 0; phase = 1;
                served.push_back(m_c);
                ack_cnt[m_c]++;
                gaps.push_back(gap_run);
                gap_run = 0;
            end
            prev_req = 4'd0;
            if (phase == 0) begin
                prev_req = i_Req; prev_data = i_Data; gap_run++;
            end
            chk("busy", {31'd0, o_fBusy}, {31'd0, phase != 0});
            case (phase)
                0: begin
                    chk("idle_txdata", {24'd0, o_TxData}, 32'd0);
                    chk("idle_ftx", {31'd0, o_fTx}, 32'd0);
                    chk("idle_framedone", {31'd0, o_fFrameDone}, 32'd0);
                end
                1: begin
                    chk("send_txdata", {24'd0, o_TxData}, {24'd0, exp_b[bidx]});
                    chk("send_ftx", {31'd0, o_fTx}, {31'd0, i_fReady});
                    chk("send_framedone", {31'd0, o_fFrameDone}, 32'd0);
                    if (i_fReady) phase = 2;
                end
                2: begin
                    chk("wait_txdata", {24'd0, o_TxData}, {24'd0, exp_b[bidx]});
                    chk("wait_ftx", {31'd0, o_fTx}, 32'd0);
                    chk("framedone", {31'd0, o_fFrameDone}, {31'd0, i_fDone && bidx == 3});
                    if (i_fDone) begin
                        if (bidx == 3) begin phase = 0; frames++; end
                        else begin bidx++; phase = 1; end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- transmitter model ----------------
    int         tx_cnt = 0;
    logic       stall = 1'b0;
    logic       auto_drop = 1'b0;
    logic [7:0] cap[$];
    int         strobes = 0;
    logic       s_tx;
    logic [7:0] s_b;
    logic [3:0] s_ack;

    // Accepts a strobe, stays busy BYTE_T cycles, pulses done, then reports ready.
    initial forever begin
        @(negedge i_Clk);
        s_tx = o_fTx; s_b = o_TxData; s_ack = o_Ack;
        @(posedge i_Clk);
        #1;
        if (!i_Rst) begin
            tx_cnt = 0; i_fDone = 1'b0; i_fReady = !stall;
        end else begin
            i_fDone = 1'b0;
            if (s_tx) begin
                strobes++; cap.push_back(s_b); tx_cnt = BYTE_T; i_fReady = 1'b0;
            end else if (tx_cnt > 1) begin
                tx_cnt--;
            end else if (tx_cnt == 1) begin
                tx_cnt = 0; i_fDone = 1'b1;
            end else begin
                i_fReady = !stall;
            end
            if (auto_drop) i_Req = i_Req & ~s_ack;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge i_Clk); #1;
        i_Rst = 1'b0; i_Req = 4'd0;
        tick(2);
        i_Rst = 1'b1;
        cap.delete(); served.delete(); gaps.delete(); strobes = 0;
        foreach (ack_cnt[i]) ack_cnt[i] = 0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames < target && n < budget) begin tick(1); n++; end
        chk(name, frames, target);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (o_fBusy && n < 200) begin tick(1); n++; end
        chk(name, {31'd0, o_fBusy}, 32'd0);
    endtask

    function automatic logic [31:0] capq(input int i);
        return (cap.size() > i) ? {24'd0, cap[i]} : 32'hDEAD_0000 + i;
    endfunction

    function automatic logic [31:0] srvq(input int i);
        return (served.size() > i) ? served[i] : 32'hDEAD_0000 + i;
    endfunction

    function automatic logic [31:0] gapq(input int i);
        return (gaps.size() > i) ? gaps[i] : 32'hDEAD_0000 + i;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int f0;
    int n;

    initial begin
        // T1: single request on ch2; data changed after grant must not matter
        apply_reset();
        auto_drop = 1'b1;
        i_Data = 32'h005A_0000;
        f0 = frames;
        i_Req = 4'b0100;
        tick(3);
        i_Data = 32'hFFFF_FFFF;
        wait_frames(f0 + 1, 200, "t1_frame");
        chk("t1_strobes", strobes, 4);
        chk("t1_b0", capq(0), 32'hA5);
        chk("t1_b1", capq(1), 32'h32);
        chk("t1_b2", capq(2), 32'h5A);
        chk("t1_b3", capq(3), 32'hCD);
        chk("t1_ack_ch2", ack_cnt[2], 1);
        chk("t1_served", srvq(0), 2);

        // T2: all four request, each drops on ack -> channel order 0..3
        apply_reset();
        i_Data = 32'h4433_2211;
        f0 = frames;
        i_Req = 4'b1111;
        wait_frames(f0 + 4, 600, "t2_frames");
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", srvq(i), i);
            chk("t2_ack_once", ack_cnt[i], 1);
        end
        chk("t2_ch1_id", capq(5), 32'h31);
        chk("t2_ch1_data", capq(6), 32'h22);
        chk("t2_ch1_sum", capq(7), 32'hB6);

        // T3: ch1 and ch3 held -> 1,3,1,3 with one idle cycle between frames
        apply_reset();
        auto_drop = 1'b0;
        i_Data = 32'h7E00_3C00;
        f0 = frames;
        i_Req = 4'b1010;
        wait_frames(f0 + 4, 600, "t3_frames");
        i_Req = 4'd0;
        wait_idle("t3_idle");
        chk("t3_s0", srvq(0), 1);
        chk("t3_s1", srvq(1), 3);
        chk("t3_s2", srvq(2), 1);
        chk("t3_s3", srvq(3), 3);
        for (int i = 1; i < 4; i++) chk("t3_gap", gapq(i), 1);

        // T3b: ch1 alone held -> consecutive ch1 frames
        served.delete(); gaps.delete();
        tick(2);
        f0 = frames;
        i_Req = 4'b0010;
        wait_frames(f0 + 2, 400, "t3b_frames");
        i_Req = 4'd0;
        wait_idle("t3b_idle");
        chk("t3b_s0", srvq(0), 1);
        chk("t3b_s1", srvq(1), 1);
        chk("t3b_gap", gapq(1), 1);

        // T4: transmitter not ready for 20+ cycles while in SEND
        apply_reset();
        auto_drop = 1'b1;
        stall = 1'b1;
        tick(2);
        strobes = 0; cap.delete();
        i_Data = 32'h0000_0011;
        f0 = frames;
        i_Req = 4'b0001;
        tick(22);
        chk("t4_no_strobe", strobes, 0);
        chk("t4_busy", {31'd0, o_fBusy}, 32'd1);
        chk("t4_hold_sync", {24'd0, o_TxData}, 32'hA5);
        stall = 1'b0;
        wait_frames(f0 + 1, 200, "t4_frame");
        chk("t4_strobes", strobes, 4);
        chk("t4_b0", capq(0), 32'hA5);
        chk("t4_b3", capq(3), 32'h84);

        // T5: reset during WAIT of byte 2, then a fresh ch1 frame
        apply_reset();
        i_Data = 32'h0077_0000;
        i_Req = 4'b0100;
        n = 0;
        while (!(phase == 2 && bidx == 2) && n < 200) begin tick(1); n++; end
        chk("t5_reach_wait2", {31'd0, phase == 2 && bidx == 2}, 32'd1);
        #2;
        i_Rst = 1'b0;
        #1;
        chk("t5_rst_ftx", {31'd0, o_fTx}, 32'd0);
        chk("t5_rst_busy", {31'd0, o_fBusy}, 32'd0);
        chk("t5_rst_ack", {28'd0, o_Ack}, 32'd0);
        chk("t5_rst_txdata", {24'd0, o_TxData}, 32'd0);
        i_Req = 4'd0;
        tick(2);
        i_Rst = 1'b1;
        cap.delete(); served.delete();
        i_Data = 32'h0000_3C00;
        f0 = frames;
        i_Req = 4'b0010;
        wait_frames(f0 + 1, 200, "t5_frame");
        chk("t5_b0", capq(0), 32'hA5);
        chk("t5_b1", capq(1), 32'h31);
        chk("t5_b2", capq(2), 32'h3C);
        chk("t5_b3", capq(3), 32'hA8);
        chk("t5_served", srvq(0), 1);

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Four-channel round-robin arbiter and frame sequencer in front of the shared UART transmitter.
- Each requester offers one payload byte. The block grants one channel at a time and sends a 4-byte frame through the transmitter's single-byte handshake: SYNC, channel ID, DATA, checksum.
- Sits between the status/debug sources and the UART transmitter instance in the top level.

Parameters:
- SYNC, 8'hA5, first byte of every frame
- ID_BASE, 8'h30, channel ID byte = ID_BASE + channel number (ASCII '0'..'3')

Ports:
- i_Clk  input  1  system clock, 50 MHz
- i_Rst  input  1  asynchronous reset, active-low
- i_Req  input  4  per-channel request, level; held high until acknowledged
- i_Data  input  32  payload bytes; channel n on bits [8n+7:8n]; stable while i_Req[n] is high
- o_Ack  output  4  one-cycle pulse; payload of that channel latched
- o_fBusy  output  1  high whenever state is not IDLE
- o_fFrameDone  output  1  one-cycle pulse when the last frame byte completes
- o_fTx  output  1  one-cycle send strobe to the UART transmitter
- o_TxData  output  8  byte presented with o_fTx
- i_fReady  input  1  transmitter idle, accepts a strobe this cycle
- i_fDone  input  1  transmitter one-cycle pulse at the end of a stop bit

Behaviour:
- Reset values: all outputs 0; state IDLE; byte index 0; round-robin pointer 3, so channel 0 has top priority after reset; latched data 0.
- **States:** IDLE, SEND, WAIT.
- **IDLE:**
  - If i_Req != 0, pick the first set bit searching from pointer+1 mod 4 upward with wrap.
  - On the next edge: latch the channel number and its data byte, set pointer = granted channel, index = 0, go to SEND.
  - o_Ack[granted] is registered and high for exactly the first SEND cycle.
- **SEND:**
  - o_fTx = i_fReady, combinational.
  - While i_fReady = 0, stay in SEND and hold o_TxData.
  - When i_fReady = 1, go to WAIT on the next edge.
- **WAIT:**
  - o_fTx = 0. Wait for i_fDone.
  - On i_fDone with index < 3: index + 1, go to SEND.
  - On i_fDone with index = 3: go to IDLE. o_fFrameDone = 1 combinationally in that cycle.
- **o_TxData by index:**
  - 0: SYNC
  - 1: ID_BASE + channel
  - 2: latched data
  - 3: SYNC ^ ID ^ data
  - o_TxData is valid in SEND and WAIT, 0 in IDLE.
- Latency: request in IDLE at edge k gives o_Ack and the first o_fTx (if ready) in cycle k+1. Total frame time = 4 UART byte times plus at most 1 cycle per byte for SEND.
- Requests arriving during a frame are not sampled. They are arbitrated in the first IDLE cycle after o_fFrameDone, so there is a minimum of one IDLE cycle between frames.
- A requester that is still requesting after being served loses to every other active requester (pointer rule). The same channel is served back-to-back only if no other channel requests.
- i_Req[n] dropped before its ack: no ack and no frame. Data is sampled only at the grant edge; later changes to i_Data do not affect the frame in flight.
- i_fDone while in SEND or IDLE: ignored.
- Reset asserted mid-frame: immediately return to reset values; o_fTx drops at once; no ack or frame-done is generated for the aborted frame.
- Arithmetic is 8-bit modulo; ID addition wraps with no carry out.

Decomposition:
- Shared UART package holds: SYNC and ID_BASE defaults, state encodings (IDLE=2'b00, SEND=2'b01, WAIT=2'b10), channel count 4.
- One natural sub-module: rr_arbiter4, a combinational priority search from pointer+1 that returns the grant index and an any-request flag. The pointer register stays in the parent.
- The checksum is inline.

Test Plan:
- Single request, ch2 data 8'h5A, model ready/done with 10-cycle bytes -> o_Ack=4'b0100 once; bytes A5, 32, 5A, CD in order; one o_fFrameDone.
- i_Req=4'b1111 held after reset, each channel dropping its request on ack -> frames in channel order 0,1,2,3; one ack per channel.
- ch1 and ch3 held continuously -> frames alternate 1,3,1,3; ch1 alone held -> consecutive ch1 frames, each separated by one IDLE cycle.
- Transmitter model holds i_fReady low for 20 cycles in SEND -> o_fTx stays 0; o_fTx pulses exactly once when ready rises; o_TxData stable throughout.
- Reset asserted during WAIT of byte 2 -> o_fTx, o_fBusy and o_Ack read 0 asynchronously; a new request after reset release starts a fresh frame with SYNC.
- Loopback through the real UART transmitter at 115200 -> the serial line decodes A5 31 xx checksum for a ch1 request; the checksum is verified by the bench.
